// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the gray_counter family.
// Functions operate on a fixed-width vector; callers zero-extend narrower values.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

    function automatic gray_vec_t bin2gray(input gray_vec_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits leave the prefix XOR of the real bits unchanged.
    function automatic gray_vec_t gray2bin(input gray_vec_t g);
        gray_vec_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit Gray-to-binary decoder (prefix XOR from the MSB).
// Also suitable for decoding synchronised Gray pointers in other clock domains.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter.sv
// Parametrised up/down Gray counter with load, wrap/saturate mode and flags.
// Optional macro GRAY_COUNTER_BIN_OUT_EN exposes bin_count and bin_next.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_count,
    output logic             tc,
    output logic             wrapped
`ifdef GRAY_COUNTER_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] bin_next
`endif
);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step_bin;
    logic             tc_c;
    cnt_dir_e         dir;

    gray_to_bin #(.WIDTH(WIDTH)) u_load_dec (
        .gray (load_gray),
        .bin  (load_bin)
    );

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        dir       = cnt_dir_e'(up);
        tc_c      = (dir == DIR_UP) ? (bin_q == {WIDTH{1'b1}}) : (bin_q == '0);
        step_bin  = (dir == DIR_UP) ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        bin_d     = bin_q;
        gray_d    = gray_q;
        wrapped_d = 1'b0;

        if (load) begin
            bin_d  = load_bin;
            gray_d = load_gray;
        end else if (en && !(SATURATE && tc_c)) begin
            // Gray register is recomputed from the next binary value, so it stays a pure flop output.
            bin_d     = step_bin;
            gray_d    = WIDTH'(bin2gray(gray_vec_t'(step_bin)));
            wrapped_d = !SATURATE && tc_c;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            gray_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign gray_count = gray_q;
    assign wrapped    = wrapped_q;
    assign tc         = tc_c;

`ifdef GRAY_COUNTER_BIN_OUT_EN
    // bin_next is the count/load path value; a coincident rst still clears the register.
    assign bin_count = bin_q;
    assign bin_next  = bin_d;
`endif

endmodule
